// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core with a single shared req/ready memory port.
// Memory states hold address/data stable until mem_ready; HALT exits only through reset.
module riscv_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halt,
  output logic        retire
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  } state_t;

  localparam logic [6:0] OPC_LW  = 7'h03;
  localparam logic [6:0] OPC_SW  = 7'h23;
  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  state_t      state;
  logic [31:0] pc, oldpc, ir, a, b, aluout, data;
  logic [31:0] rf [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rf_a, rf_b, alu_y, alu_res;
  logic        illegal, take;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rf_a    = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rf_b    = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign illegal = !(opcode inside {OPC_LW, OPC_SW, OPC_R, OPC_I, OPC_BR, OPC_JAL});
  // Only beq/bne are decoded; other branch funct3 values fall through untaken.
  assign take    = ((f3 == 3'd0) && (a == b)) || ((f3 == 3'd1) && (a != b));

  always_comb begin
    alu_y   = (state == EXECR) ? b : imm_i;
    alu_res = 32'd0;
    case (f3)
      3'd0:    alu_res = (state == EXECR && ir[30]) ? a - alu_y : a + alu_y;
      3'd2:    alu_res = {31'd0, $signed(a) < $signed(alu_y)};
      3'd6:    alu_res = a | alu_y;
      3'd7:    alu_res = a & alu_y;
      default: alu_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          oldpc <= pc;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a <= rf_a;
          b <= rf_b;
          case (opcode)
            OPC_LW, OPC_SW: state <= MEMADR;
            OPC_R:          state <= EXECR;
            OPC_I:          state <= EXECI;
            OPC_BR:         state <= BRANCH;
            OPC_JAL:        state <= JAL;
            default:        state <= HALT_ON_ILLEGAL ? HALT : FETCH;
          endcase
        end
        MEMADR: begin
          aluout <= a + ((opcode == OPC_SW) ? imm_s : imm_i);
          state  <= (opcode == OPC_SW) ? MEMWRITE : MEMREAD;
        end
        MEMREAD: if (mem_ready) begin
          data  <= mem_rdata;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rd != 5'd0) rf[rd] <= data;
          state <= FETCH;
        end
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR, EXECI: begin
          aluout <= alu_res;
          state  <= ALUWB;
        end
        ALUWB: begin
          if (rd != 5'd0) rf[rd] <= aluout;
          state <= FETCH;
        end
        BRANCH: begin
          if (take) pc <= oldpc + imm_b;
          state <= FETCH;
        end
        JAL: begin
          if (rd != 5'd0) rf[rd] <= oldpc + 32'd4;
          pc    <= oldpc + imm_j;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

  assign mem_req   = !reset && (state == FETCH || state == MEMREAD || state == MEMWRITE);
  assign mem_we    = !reset && (state == MEMWRITE);
  assign mem_addr  = (state == FETCH) ? pc : aluout;
  assign mem_wdata = b;
  assign halt      = !reset && (state == HALT);
  assign retire    = !reset && (state == MEMWB || state == ALUWB || state == BRANCH ||
                                state == JAL || (state == MEMWRITE && mem_ready) ||
                                (state == DECODE && illegal && !HALT_ON_ILLEGAL));

endmodule

// File: tb/tb_riscv_multicycle.sv
// Bench for riscv_multicycle: directed vectors, corner sequences and random programs
// checked against an instruction-level reference model.
module tb_riscv_multicycle;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halt, retire;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  riscv_multicycle #(.RESET_PC(32'h100), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halt(halt), .retire(retire)
  );

  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_SLT = 4, OP_ADDI = 5,
                 OP_ANDI = 6, OP_ORI = 7, OP_SLTI = 8, OP_LW = 9, OP_SW = 10, OP_BEQ = 11,
                 OP_BNE = 12, OP_JAL = 13, OP_ILL = 14;

  typedef struct { int op; int rd; int rs1; int rs2; int imm; } ins_t;
  typedef struct { int op; logic [31:0] a; logic [31:0] b; int imm; logic [31:0] exp; } vec_t;

  logic [31:0] img [0:255];
  logic [31:0] ovl [0:255];
  logic [255:0] wr_v;
  logic [63:0] wr_q [$];
  int          ret_cyc [$];
  int          cyc;
  int          total = 0, bad = 0;
  bit          rdy_rand = 1'b0;
  int          data_wait = 0;
  int          wcnt = 0;
  bit          rnd_bit = 1'b1;
  int          hs_bad = 0, hs_n = 0;
  bit          hold_v = 1'b0;
  logic [64:0] hold_s;

  ins_t        prog [$];
  vec_t        vt [13];
  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  int          exp_ret;

  // Memory model: program image plus a write overlay cleared on reset.
  assign mem_rdata = wr_v[mem_addr[9:2]] ? ovl[mem_addr[9:2]] : img[mem_addr[9:2]];
  assign mem_ready = rdy_rand ? rnd_bit : ((mem_addr >= 32'h100) || (wcnt >= data_wait));

  always @(posedge clk) begin
    rnd_bit <= ($urandom_range(0, 3) != 0);
    if (reset || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      ret_cyc.delete();
      wr_q.delete();
      wr_v = '0;
      hold_v = 1'b0;
    end else begin
      cyc++;
      if (retire) ret_cyc.push_back(cyc);
      if (mem_req && mem_ready && mem_we) begin
        ovl[mem_addr[9:2]] = mem_wdata;
        wr_v[mem_addr[9:2]] = 1'b1;
        wr_q.push_back({mem_addr, mem_wdata});
      end
      if (hold_v) begin
        hs_n++;
        if (!mem_req || hold_s != {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0}) hs_bad++;
      end
      hold_v = mem_req && !mem_ready;
      hold_s = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ins_t mk(int op, int rd, int rs1, int rs2, int imm);
    ins_t t;
    t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic logic [31:0] encode(ins_t t);
    logic [31:0] im;
    logic [4:0]  d, s1, s2;
    im = t.imm; d = 5'(t.rd); s1 = 5'(t.rs1); s2 = 5'(t.rs2);
    case (t.op)
      OP_ADD:  return {7'h00, s2, s1, 3'd0, d, 7'h33};
      OP_SUB:  return {7'h20, s2, s1, 3'd0, d, 7'h33};
      OP_AND:  return {7'h00, s2, s1, 3'd7, d, 7'h33};
      OP_OR:   return {7'h00, s2, s1, 3'd6, d, 7'h33};
      OP_SLT:  return {7'h00, s2, s1, 3'd2, d, 7'h33};
      OP_ADDI: return {im[11:0], s1, 3'd0, d, 7'h13};
      OP_ANDI: return {im[11:0], s1, 3'd7, d, 7'h13};
      OP_ORI:  return {im[11:0], s1, 3'd6, d, 7'h13};
      OP_SLTI: return {im[11:0], s1, 3'd2, d, 7'h13};
      OP_LW:   return {im[11:0], s1, 3'd2, d, 7'h03};
      OP_SW:   return {im[11:5], s2, s1, 3'd2, im[4:0], 7'h23};
      OP_BEQ:  return {im[12], im[10:5], s2, s1, 3'd0, im[4:1], im[11], 7'h63};
      OP_BNE:  return {im[12], im[10:5], s2, s1, 3'd1, im[4:1], im[11], 7'h63};
      OP_JAL:  return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
      default: return 32'h0000_007F;
    endcase
  endfunction

  task automatic load();
    for (int k = 64; k < 256; k++) img[k] = 32'h0000_007F;
    for (int k = 0; k < prog.size(); k++) img[64 + k] = encode(prog[k]);
  endtask

  task automatic restart();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input string nm, input int budget);
    int n = 0;
    while (!halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, halt}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string nm, input int k, input logic [31:0] a, input logic [31:0] d);
    if (k >= wr_q.size()) check({nm, "_present"}, 32'd0, 32'd1);
    else begin
      check({nm, "_addr"}, wr_q[k][63:32], a);
      check({nm, "_data"}, wr_q[k][31:0], d);
    end
  endtask

  // Instruction-level reference: walks the program list by index with plain arithmetic.
  task automatic model();
    logic [31:0] r [0:31];
    logic [31:0] dm [0:63];
    logic [31:0] sx, pcv;
    ins_t        it;
    int          idx, nxt, steps;
    for (int k = 0; k < 32; k++) r[k] = 32'd0;
    for (int k = 0; k < 64; k++) dm[k] = img[k];
    exp_wa.delete(); exp_wd.delete();
    exp_ret = 0; idx = 0; steps = 0;
    while (idx >= 0 && idx < prog.size() && steps < 1000) begin
      it = prog[idx];
      if (it.op == OP_ILL) break;
      sx = it.imm; pcv = 32'h100 + 32'(4 * idx); nxt = idx + 1; steps++;
      case (it.op)
        OP_ADD:  r[it.rd] = r[it.rs1] + r[it.rs2];
        OP_SUB:  r[it.rd] = r[it.rs1] - r[it.rs2];
        OP_AND:  r[it.rd] = r[it.rs1] & r[it.rs2];
        OP_OR:   r[it.rd] = r[it.rs1] | r[it.rs2];
        OP_SLT:  r[it.rd] = ($signed(r[it.rs1]) < $signed(r[it.rs2])) ? 32'd1 : 32'd0;
        OP_ADDI: r[it.rd] = r[it.rs1] + sx;
        OP_ANDI: r[it.rd] = r[it.rs1] & sx;
        OP_ORI:  r[it.rd] = r[it.rs1] | sx;
        OP_SLTI: r[it.rd] = ($signed(r[it.rs1]) < $signed(sx)) ? 32'd1 : 32'd0;
        OP_LW:   r[it.rd] = dm[sx[7:2]];
        OP_SW:   begin dm[sx[7:2]] = r[it.rs2]; exp_wa.push_back(sx); exp_wd.push_back(r[it.rs2]); end
        OP_BEQ:  if (r[it.rs1] == r[it.rs2]) nxt = idx + it.imm / 4;
        OP_BNE:  if (r[it.rs1] != r[it.rs2]) nxt = idx + it.imm / 4;
        OP_JAL:  begin r[it.rd] = pcv + 32'd4; nxt = idx + it.imm / 4; end
        default: ;
      endcase
      r[0] = 32'd0;
      exp_ret++;
      idx = nxt;
    end
  endtask

  task automatic gen();
    int op, imm;
    prog.delete();
    for (int k = 1; k < 8; k++) prog.push_back(mk(OP_ADDI, k, 0, 0, int'($urandom_range(0, 4095)) - 2048));
    for (int k = 0; k < 20; k++) begin
      op = int'($urandom_range(0, 13));
      if (op == OP_LW || op == OP_SW) imm = 4 * int'($urandom_range(0, 63));
      else if (op >= OP_BEQ) imm = 8;
      else imm = int'($urandom_range(0, 4095)) - 2048;
      prog.push_back(mk(op, int'($urandom_range(0, 7)),
                        (op == OP_LW || op == OP_SW) ? 0 : int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), imm));
    end
    for (int k = 1; k < 8; k++) prog.push_back(mk(OP_SW, 0, 0, k, 32'hE0 + 4 * k));
    prog.push_back(mk(OP_ILL, 0, 0, 0, 0));
  endtask

  initial begin
    int viol, nr, nw;
    bit seen;
    vt[0]  = '{OP_ADD,  32'd5,         32'd7,         0,     32'd12};
    vt[1]  = '{OP_SUB,  32'd3,         32'd5,         0,     32'hFFFF_FFFE};
    vt[2]  = '{OP_SUB,  32'h8000_0000, 32'd1,         0,     32'h7FFF_FFFF};
    vt[3]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         0,     32'd1};
    vt[4]  = '{OP_SLT,  32'd1,         32'hFFFF_FFFF, 0,     32'd0};
    vt[5]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 0,     32'h00F0_1200};
    vt[6]  = '{OP_OR,   32'hF000_0000, 32'h0000_000F, 0,     32'hF000_000F};
    vt[7]  = '{OP_ADDI, 32'd0,         32'd0,         -1,    32'hFFFF_FFFF};
    vt[8]  = '{OP_ADDI, 32'hFFFF_FFFF, 32'd0,         1,     32'd0};
    vt[9]  = '{OP_SLTI, 32'hFFFF_FFF0, 32'd0,         5,     32'd1};
    vt[10] = '{OP_SLTI, 32'd5,         32'd0,         -16,   32'd0};
    vt[11] = '{OP_ANDI, 32'h1234_5678, 32'd0,         -256,  32'h1234_5600};
    vt[12] = '{OP_ORI,  32'd5,         32'd0,         2032,  32'h0000_07F5};
    for (int k = 0; k < 64; k++) img[k] = 32'd0;

    // Reset state and first fetch
    prog.delete();
    prog.push_back(mk(OP_ADDI, 1, 0, 0, 1));
    load();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_flags", {29'd0, mem_we, halt, retire}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("fetch0_req", {30'd0, mem_req, mem_we}, 32'd2);
    check("fetch0_addr", mem_addr, 32'h100);

    // Zero-wait sequence with retire timing
    prog.delete();
    prog.push_back(mk(OP_ADDI, 1, 0, 0, 5));
    prog.push_back(mk(OP_ADDI, 2, 0, 0, 7));
    prog.push_back(mk(OP_ADD, 3, 1, 2, 0));
    prog.push_back(mk(OP_SW, 0, 0, 3, 8));
    load();
    restart();
    wait_halt("seq2_halt", 200);
    check("seq2_nret", ret_cyc.size(), 32'd4);
    for (int k = 0; k < 4 && k < ret_cyc.size(); k++) check("seq2_retcyc", ret_cyc[k], 32'(4 * (k + 1)));
    check("seq2_nwr", wr_q.size(), 32'd1);
    check_wr("seq2_wr", 0, 32'h8, 32'd12);

    // Table-driven ALU vectors
    foreach (vt[i]) begin
      img[0] = vt[i].a; img[1] = vt[i].b;
      prog.delete();
      prog.push_back(mk(OP_LW, 1, 0, 0, 0));
      prog.push_back(mk(OP_LW, 2, 0, 0, 4));
      if (vt[i].op >= OP_ADDI) prog.push_back(mk(vt[i].op, 3, 1, 0, vt[i].imm));
      else prog.push_back(mk(vt[i].op, 3, 1, 2, 0));
      prog.push_back(mk(OP_SW, 0, 0, 3, 8));
      load();
      restart();
      wait_halt("vec_halt", 200);
      check("vec_nwr", wr_q.size(), 32'd1);
      check_wr($sformatf("vec%0d", i), 0, 32'h8, vt[i].exp);
    end

    // Load with three data wait states, x0 write dropped
    img[0] = 32'hCAFE_F00D; img[2] = 32'hDEAD_BEEF;
    prog.delete();
    prog.push_back(mk(OP_LW, 4, 0, 0, 0));
    prog.push_back(mk(OP_ADD, 0, 4, 4, 0));
    prog.push_back(mk(OP_SW, 0, 0, 4, 4));
    prog.push_back(mk(OP_SW, 0, 0, 0, 8));
    load();
    data_wait = 3;
    restart();
    wait_halt("lw_halt", 400);
    data_wait = 0;
    check("lw_cycles", (ret_cyc.size() > 0) ? ret_cyc[0] : -1, 32'd8);
    check("lw_nwr", wr_q.size(), 32'd2);
    check_wr("lw_x4", 0, 32'h4, 32'hCAFE_F00D);
    check_wr("lw_x0", 1, 32'h8, 32'd0);

    // Counted loop with bne, then jal link/target
    prog.delete();
    prog.push_back(mk(OP_ADDI, 1, 0, 0, 3));
    prog.push_back(mk(OP_ADDI, 7, 0, 0, 0));
    prog.push_back(mk(OP_ADDI, 1, 1, 0, -1));
    prog.push_back(mk(OP_ADDI, 7, 7, 0, 1));
    prog.push_back(mk(OP_BNE, 0, 1, 0, -8));
    prog.push_back(mk(OP_JAL, 5, 0, 0, 8));
    prog.push_back(mk(OP_ILL, 0, 0, 0, 0));
    prog.push_back(mk(OP_SW, 0, 0, 7, 16));
    prog.push_back(mk(OP_SW, 0, 0, 5, 20));
    prog.push_back(mk(OP_SW, 0, 0, 1, 24));
    load();
    restart();
    wait_halt("loop_halt", 400);
    check("loop_nret", ret_cyc.size(), 32'd15);
    check("loop_nwr", wr_q.size(), 32'd3);
    check_wr("loop_iter", 0, 32'h10, 32'd3);
    check_wr("loop_link", 1, 32'h14, 32'h118);
    check_wr("loop_x1", 2, 32'h18, 32'd0);

    // Illegal opcode halts until reset
    prog.delete();
    load();
    restart();
    wait_halt("ill_halt", 50);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (!halt || mem_req || retire) viol++;
    end
    check("ill_hold", viol, 32'd0);
    check("ill_nret", ret_cyc.size(), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("ill_rst_halt", {31'd0, halt}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ill_refetch", {mem_req, mem_we, mem_addr[29:0]}, {2'b10, 30'h100});

    // Reset while a store waits
    img[0] = 32'h1111_1111;
    prog.delete();
    prog.push_back(mk(OP_SW, 0, 0, 0, 0));
    load();
    data_wait = 1000;
    restart();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = mem_req && mem_we;
    end
    check("rw_store_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    nr = ret_cyc.size(); nw = wr_q.size();
    check("rw_no_retire", nr, 32'd0);
    check("rw_no_write", nw, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rw_rst_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1 begin reset = 1'b0; data_wait = 0; end
    @(negedge clk);
    check("rw_refetch", {mem_req, mem_we, mem_addr[29:0]}, {2'b10, 30'h100});
    wait_halt("rw_halt", 100);
    check("rw_nwr", wr_q.size(), 32'd1);

    // Random programs, random wait states
    rdy_rand = 1'b1;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 64; k++) img[k] = $urandom;
      gen();
      load();
      model();
      restart();
      wait_halt("rnd_halt", 4000);
      check("rnd_nret", ret_cyc.size(), exp_ret);
      check("rnd_nwr", wr_q.size(), exp_wa.size());
      for (int k = 0; k < exp_wa.size(); k++) check_wr($sformatf("rnd%0d_wr%0d", p, k), k, exp_wa[k], exp_wd[k]);
    end
    rdy_rand = 1'b0;

    check("hs_stable", hs_bad, 32'd0);
    check("hs_seen", {31'd0, hs_n > 0}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
